// File: rtl/scemi_input_pipe_unpacker.sv
// Input-pipe unpacker: takes multi-element payloads from a transactor front end,
// serializes them into an element FIFO and presents one element per cycle.
// Message boundaries survive, including zero-length end-of-message markers.
//
// Handshakes: a transfer happens on a rising clk edge where valid & ready are
// both high. The producer holds valid and its payload stable until that edge.
// Ready never depends on valid in the same cycle.
module scemi_input_pipe_unpacker #(
  parameter int BYTES_PER_ELEMENT    = 1,
  parameter int PAYLOAD_MAX_ELEMENTS = 4,
  parameter int BUFFER_MAX_ELEMENTS  = 16,
  localparam int EW = BYTES_PER_ELEMENT * 8,
  localparam int PW = PAYLOAD_MAX_ELEMENTS * EW,
  localparam int NW = $clog2(PAYLOAD_MAX_ELEMENTS + 1),
  localparam int CW = $clog2(BUFFER_MAX_ELEMENTS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [NW-1:0] in_num_elements,
  input  logic [PW-1:0] in_data,
  input  logic          in_eom,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [EW-1:0] out_data,
  output logic          out_eom,
  output logic          out_nodata,
  output logic [CW-1:0] level,
  output logic          err_overlen,
  output logic [1:0]    dbg_state
);

  localparam int AW = $clog2(BUFFER_MAX_ELEMENTS);

  typedef enum logic [1:0] {IDLE = 2'd0, UNPACK = 2'd1, MARK = 2'd2} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] pay_data;
  logic          pay_eom;
  logic [NW-1:0] pay_n;
  logic [NW-1:0] idx;
  logic [NW-1:0] n_clamped;
  logic          accept;
  logic          full;
  logic          push;
  logic          pop;
  logic          last_elem;
  logic [EW-1:0] push_data;
  logic          push_eom;
  logic          push_nodata;

  logic [EW-1:0] mem_data   [BUFFER_MAX_ELEMENTS];
  logic          mem_eom    [BUFFER_MAX_ELEMENTS];
  logic          mem_nodata [BUFFER_MAX_ELEMENTS];
  logic [AW-1:0] wr_ptr, rd_ptr;

  assign dbg_state = state;
  assign in_ready  = (state == IDLE) && !rst;
  assign accept    = in_valid && in_ready;
  assign n_clamped = (in_num_elements > NW'(PAYLOAD_MAX_ELEMENTS))
                     ? NW'(PAYLOAD_MAX_ELEMENTS) : in_num_elements;
  // Full uses the registered level only; a same-cycle pop does not free a slot.
  assign full      = (level == CW'(BUFFER_MAX_ELEMENTS));
  assign last_elem = (idx == pay_n - NW'(1));
  assign pop       = out_valid && out_ready;

  // Next-state logic and the entry to be written into the FIFO this cycle.
  always_comb begin
    state_nxt   = state;
    push        = 1'b0;
    push_data   = '0;
    push_eom    = 1'b0;
    push_nodata = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (n_clamped != '0) state_nxt = UNPACK;
          else if (in_eom)     state_nxt = MARK;
        end
      end
      UNPACK: begin
        if (!full) begin
          push      = 1'b1;
          push_data = pay_data[idx*EW +: EW];
          push_eom  = pay_eom && last_elem;
          if (last_elem) state_nxt = IDLE;
        end
      end
      MARK: begin
        if (!full) begin
          push        = 1'b1;
          push_eom    = 1'b1;
          push_nodata = 1'b1;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register, latched payload, element index and sticky overlength flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pay_data    <= '0;
      pay_eom     <= 1'b0;
      pay_n       <= '0;
      idx         <= '0;
      err_overlen <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        pay_data <= in_data;
        pay_eom  <= in_eom;
        pay_n    <= n_clamped;
        idx      <= '0;
        if (in_num_elements > NW'(PAYLOAD_MAX_ELEMENTS)) err_overlen <= 1'b1;
      end else if (push && state == UNPACK) begin
        idx <= idx + NW'(1);
      end
    end
  end

  // FIFO storage; contents are qualified by level so need no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr]   <= push_data;
      mem_eom[wr_ptr]    <= push_eom;
      mem_nodata[wr_ptr] <= push_nodata;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + CW'(1);
        2'b01:   level <= level - CW'(1);
        default: level <= level;
      endcase
    end
  end

  // Head entry drives the outputs; forced to zero when the FIFO is empty.
  always_comb begin
    out_valid  = (level != '0);
    out_data   = '0;
    out_eom    = 1'b0;
    out_nodata = 1'b0;
    if (out_valid) begin
      out_data   = mem_data[rd_ptr];
      out_eom    = mem_eom[rd_ptr];
      out_nodata = mem_nodata[rd_ptr];
    end
  end

endmodule

// File: tb/tb_scemi_input_pipe_unpacker.sv
// Directed bench for scemi_input_pipe_unpacker with an expected-entry queue.
module tb_scemi_input_pipe_unpacker;

  localparam int EW = 8;
  localparam int PW = 32;
  localparam int NW = 3;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [NW-1:0] in_num_elements = '0;
  logic [PW-1:0] in_data = '0;
  logic          in_eom = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [EW-1:0] out_data;
  logic          out_eom;
  logic          out_nodata;
  logic [CW-1:0] level;
  logic          err_overlen;
  logic [1:0]    dbg_state;

  int tests_run = 0;
  int errors    = 0;

  // Expected entries: {nodata, eom, data}
  logic [9:0] exp_q[$];

  scemi_input_pipe_unpacker dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_num_elements(in_num_elements), .in_data(in_data), .in_eom(in_eom),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_eom(out_eom), .out_nodata(out_nodata),
    .level(level), .err_overlen(err_overlen), .dbg_state(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every consumed head entry must match the queue front.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected", {22'b0, out_nodata, out_eom, out_data}, 32'hFFFF_FFFF);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        check("sb_entry", {22'b0, out_nodata, out_eom, out_data}, {22'b0, e});
      end
    end
  end

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 out_ready = v;
  endtask

  // Pushes the expected entries, then offers the payload until accepted.
  task automatic send(input int n, input logic [31:0] data, input logic eom);
    int m;
    bit got;
    m = (n > 4) ? 4 : n;
    for (int i = 0; i < m; i++)
      exp_q.push_back({1'b0, eom && (i == m - 1), data[i*8 +: 8]});
    if (m == 0 && eom) exp_q.push_back({1'b1, 1'b1, 8'h00});
    got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (in_ready) got = 1;
    end
    if (!got) check("send_timeout", 0, 1);
    in_valid        = 1'b1;
    in_num_elements = NW'(n);
    in_data         = data;
    in_eom          = eom;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    check({tag, "_left"}, exp_q.size(), 0);
    check({tag, "_level"}, level, 0);
  endtask

  initial begin
    logic [31:0] d;
    // Reset
    #2 rst = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_level", level, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", in_ready, 1);
    check("idle_out_valid", out_valid, 0);
    check("idle_level", level, 0);
    check("idle_err", err_overlen, 0);
    check("idle_out_fields", {out_data, out_eom, out_nodata}, 0);
    check("idle_state", dbg_state, 0);

    // 3-element payload, latency and eom placement
    set_ready(1);
    exp_q.push_back(10'h0AA);
    exp_q.push_back(10'h0BB);
    exp_q.push_back(10'h1CC);
    @(negedge clk);
    check("p3_ready_before", in_ready, 1);
    in_valid = 1'b1; in_num_elements = 3'd3; in_data = 32'h00CCBBAA; in_eom = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("p3_t1_valid", out_valid, 0);
    check("p3_t1_in_ready", in_ready, 0);
    @(negedge clk);
    check("p3_e0", {out_valid, out_eom, out_data}, {1'b1, 1'b0, 8'hAA});
    check("p3_e0_in_ready", in_ready, 0);
    @(negedge clk);
    check("p3_e1", {out_valid, out_eom, out_data}, {1'b1, 1'b0, 8'hBB});
    @(negedge clk);
    check("p3_e2", {out_valid, out_eom, out_data}, {1'b1, 1'b1, 8'hCC});
    check("p3_in_ready_back", in_ready, 1);
    @(negedge clk);
    check("p3_empty", out_valid, 0);

    // Zero-length payloads: eom marker, then a dropped one
    set_ready(0);
    send(0, 32'h0, 1'b1);
    check("mark_state", dbg_state, 2);
    @(negedge clk);
    check("mark_level", level, 1);
    check("mark_head", {out_valid, out_nodata, out_eom}, 3'b111);
    send(0, 32'h0, 1'b0);
    @(negedge clk);
    check("drop_level", level, 1);
    check("drop_state", dbg_state, 0);
    set_ready(1);
    drain("mark");

    // Backpressure: five 4-element payloads into a 16-deep FIFO
    set_ready(0);
    for (int k = 0; k < 5; k++) begin
      d = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
      send(4, d, 1'b0);
    end
    repeat (3) @(negedge clk);
    check("full_level", level, 16);
    check("full_in_ready", in_ready, 0);
    check("full_state", dbg_state, 1);
    check("full_head", {out_valid, out_data}, {1'b1, 8'h00});
    set_ready(1);
    drain("full");
    check("full_after_ready", in_ready, 1);

    // Overlength payload is clamped to 4 elements and flagged
    send(7, 32'h44332211, 1'b1);
    check("over_err", err_overlen, 1);
    drain("over");
    repeat (5) @(negedge clk);
    check("over_err_sticky", err_overlen, 1);

    // Reset in the middle of unpacking
    set_ready(0);
    send(4, 32'hA3A2A1A0, 1'b0);
    send(4, 32'hB3B2B1B0, 1'b0);
    @(negedge clk);
    check("mid_level", level, 5);
    check("mid_state", dbg_state, 1);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_level", level, 0);
    check("mid_rst_in_ready", in_ready, 0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_err", err_overlen, 0);
    check("post_rst_valid", out_valid, 0);
    set_ready(1);
    send(2, 32'h0000BEEF, 1'b1);
    drain("post");

    check("final_queue", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, errors);
    $finish;
  end

endmodule

// File: doc/scemi_input_pipe_unpacker.md
Name: scemi_input_pipe_unpacker

Overview:
- Synthesizable HDL-side consumer of an input pipe.
- Accepts multi-element payloads (element count, data, end-of-message flag), as returned by a pipe receive call, from a transactor front end.
- Serializes them into an element FIFO and presents one element per cycle to the DUT over valid/ready.
- Preserves message boundaries, including zero-length end-of-message markers.

Parameters:
- BYTES_PER_ELEMENT, 1, bytes per element; EW = BYTES_PER_ELEMENT*8.
- PAYLOAD_MAX_ELEMENTS, 4, max elements per accepted payload; PW = PAYLOAD_MAX_ELEMENTS*EW.
- BUFFER_MAX_ELEMENTS, 16, FIFO depth in entries; power of 2, >= 2.
- Localparams: NW = $clog2(PAYLOAD_MAX_ELEMENTS+1); CW = $clog2(BUFFER_MAX_ELEMENTS+1).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  payload offered.
- in_ready  output  1  payload accepted when in_valid & in_ready.
- in_num_elements  input  NW  valid elements in in_data, 0..PAYLOAD_MAX_ELEMENTS.
- in_data  input  PW  element i at bits [i*EW +: EW].
- in_eom  input  1  payload ends a message.
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  DUT consumes head when out_valid & out_ready.
- out_data  output  EW  head element data.
- out_eom  output  1  head is last entry of its message.
- out_nodata  output  1  head is a zero-length EOM marker; out_data is don't-care.
- level  output  CW  current FIFO occupancy.
- err_overlen  output  1  sticky: a payload with in_num_elements > PAYLOAD_MAX_ELEMENTS was accepted.

Behaviour:
- Reset (async assert, sync deassert use):
  - state=IDLE, FIFO empty, level=0.
  - in_ready=0 while rst=1, 1 after reset.
  - out_valid=0, out_data=0, out_eom=0, out_nodata=0, err_overlen=0.
  - Reset mid-UNPACK discards the latched payload and all FIFO contents.
- FSM states: IDLE, UNPACK, MARK.
  - in_ready = (state==IDLE).
- IDLE, on accept:
  - Latch in_data, in_eom and n = min(in_num_elements, PAYLOAD_MAX_ELEMENTS).
  - If in_num_elements > PAYLOAD_MAX_ELEMENTS, set err_overlen.
  - Reset element index idx=0.
  - Next state: n>0 -> UNPACK; n==0 & eom -> MARK; n==0 & !eom -> stay IDLE (payload dropped, no FIFO write).
- UNPACK:
  - Each cycle with level < BUFFER_MAX_ELEMENTS (registered value, pre-pop), write entry {data=element idx, eom=(latched eom & idx==n-1), nodata=0} and increment idx.
  - After writing idx==n-1, go to IDLE.
  - If FIFO is full, stall in UNPACK; idx holds.
- MARK:
  - When level < BUFFER_MAX_ELEMENTS, write {data=0, eom=1, nodata=1}, then go to IDLE.
- FIFO:
  - Registered storage with wrapping read/write pointers of $clog2(BUFFER_MAX_ELEMENTS) bits.
  - out_* are driven combinationally from the head entry.
  - out_valid = (level != 0).
  - A write in cycle T is visible at out_valid in cycle T+1.
  - Simultaneous push and pop: level unchanged, both pointers advance.
  - Full check does not use same-cycle pop; a full FIFO stalls one extra cycle.
- Latency and throughput:
  - Payload accepted in cycle T; element 0 is written in T+1 and presented in T+2 (empty FIFO, no stall).
  - An n-element payload occupies the input for n+1 cycles (accept + n writes).
- Output stability: while out_valid & !out_ready, out_data, out_eom and out_nodata hold.
- level never exceeds BUFFER_MAX_ELEMENTS; pop with level==0 is impossible because out_valid=0.

Test Plan:
- Reset then idle -> in_ready=1, out_valid=0, level=0, err_overlen=0.
- Payload n=3, data=0x00CCBBAA, eom=1, out_ready=1 -> out_data AA, BB, CC on consecutive cycles starting T+2; out_eom=1 only on CC; in_ready returns to 1 at T+4.
- Payloads n=0/eom=1 and n=0/eom=0 -> exactly one entry with out_nodata=1, out_eom=1; the second payload produces no entry; level peaks at 1.
- out_ready=0; stream five 4-element payloads, all eom=0 -> level saturates at 16; 5th payload stalls in UNPACK with in_ready=0; raise out_ready -> all 20 elements emerge in order 0..19, no loss or duplication.
- in_num_elements=7 (max 4), eom=1 -> exactly 4 elements written, last with eom=1; err_overlen=1 and stays 1 until reset.
- Assert rst during UNPACK with level=5 -> immediately out_valid=0, level=0, in_ready=0; after deassert in_ready=1 and a new payload unpacks correctly.
